// File: rtl/ir_track_emulator_pkg.sv
// Shared definitions for the IR track emulator and its direction-test controller.
// Holds direction encodings, default track geometry and the bounce FSM states.
package ir_track_emulator_pkg;

  localparam logic FW = 1'b1;
  localparam logic BW = 1'b0;

  localparam int DEF_POS_W    = 10;
  localparam int DEF_POS_MAX  = 1000;
  localparam int DEF_HOME_POS = 0;
  localparam int DEF_P1       = 200;
  localparam int DEF_P2       = 250;
  localparam int DEF_P3       = 300;
  localparam int DEF_LEN      = 160;

  typedef enum logic {IDLE, GLITCH} bounce_state_e;

endpackage

// File: rtl/ir_track_emulator_bounce_gen.sv
// Per-sensor output stage: follows the ideal beam level one cycle late and,
// on every change, emits BOUNCE_N old/new glitch pairs before settling.
module ir_bounce_gen
  import ir_track_emulator_pkg::*;
#(
  parameter int BOUNCE_N = 0
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic ideal,
  output logic ir
);

  localparam int CNT_W = $clog2(2 * BOUNCE_N + 2);
  localparam logic [CNT_W-1:0] GLITCHES = CNT_W'(2 * BOUNCE_N);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  bounce_state_e state, state_next;
  logic level, level_next;
  logic ir_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      level <= 1'b1;
      ir    <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_next;
      level <= level_next;
      ir    <= ir_next;
      cnt   <= cnt_next;
    end
  end

  // A fresh ideal change always wins, restarting the glitch train toward it.
  always_comb begin
    state_next = state;
    level_next = level;
    ir_next    = ir;
    cnt_next   = cnt;
    if (ideal != level) begin
      level_next = ideal;
      ir_next    = ideal;
      cnt_next   = GLITCHES;
      state_next = (BOUNCE_N > 0) ? GLITCH : IDLE;
    end else if (state == GLITCH) begin
      ir_next  = ~ir;
      cnt_next = cnt - ONE;
      if (cnt == ONE) begin
        state_next = IDLE;
      end
    end
  end

endmodule

// File: rtl/ir_track_emulator.sv
// Plant model of the motor carriage and its three IR break-beam sensors:
// steps a virtual carriage from en/dir and drives IR1..IR3 from track geometry.
module ir_track_emulator
  import ir_track_emulator_pkg::*;
#(
  parameter int POS_W    = DEF_POS_W,
  parameter int POS_MAX  = DEF_POS_MAX,
  parameter int HOME_POS = DEF_HOME_POS,
  parameter int P1       = DEF_P1,
  parameter int P2       = DEF_P2,
  parameter int P3       = DEF_P3,
  parameter int LEN      = DEF_LEN,
  parameter int STEP_DIV = 4,
  parameter int BOUNCE_N = 0
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             en,
  input  logic             dir,
  output logic             IR1,
  output logic             IR2,
  output logic             IR3,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             stall
);

  if (!(P1 < P2 && P2 < P3 && P3 <= POS_MAX)) begin : g_bad_order
    $error("ir_track_emulator: beam positions out of order");
  end
  if (!(LEN > P3 - P1)) begin : g_bad_len
    $error("ir_track_emulator: carriage shorter than beam span");
  end
  if (!(HOME_POS + LEN - 1 < P1)) begin : g_bad_home
    $error("ir_track_emulator: home position already blocks IR1");
  end
  if (STEP_DIV < 1) begin : g_bad_div
    $error("ir_track_emulator: STEP_DIV must be at least 1");
  end

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_HOME = POS_W'(HOME_POS);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam int EXT_W = POS_W + 1;

  logic [PRE_W-1:0] presc;
  logic run;

  // run is en delayed one cycle, so a step already due still completes when en drops.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      presc <= '0;
      run   <= 1'b0;
    end else begin
      run <= en;
      if (!en || presc == PRE_LAST) begin
        presc <= '0;
      end else begin
        presc <= presc + PRE_ONE;
      end
    end
  end

  assign step = run && (presc == PRE_LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pos   <= POS_HOME;
      stall <= 1'b0;
    end else begin
      if (step) begin
        if (dir == FW && pos < POS_TOP) begin
          pos   <= pos + POS_ONE;
          stall <= 1'b0;
        end else if (dir == BW && pos != '0) begin
          pos   <= pos - POS_ONE;
          stall <= 1'b0;
        end else begin
          stall <= 1'b1;
        end
      end
      if (!en) begin
        stall <= 1'b0;
      end
    end
  end

  // Carriage span is compared one bit wider so pos+LEN-1 cannot wrap.
  logic [EXT_W-1:0] span_lo, span_hi;
  logic [2:0] ideal;
  logic [2:0] ir_bus;

  assign span_lo  = {1'b0, pos};
  assign span_hi  = span_lo + EXT_W'(LEN - 1);
  assign ideal[0] = !((span_lo <= EXT_W'(P1)) && (EXT_W'(P1) <= span_hi));
  assign ideal[1] = !((span_lo <= EXT_W'(P2)) && (EXT_W'(P2) <= span_hi));
  assign ideal[2] = !((span_lo <= EXT_W'(P3)) && (EXT_W'(P3) <= span_hi));

  for (genvar i = 0; i < 3; i++) begin : g_sensor
    ir_bounce_gen #(.BOUNCE_N(BOUNCE_N)) u_bounce (
      .CLK  (CLK),
      .RSTn (RSTn),
      .ideal(ideal[i]),
      .ir   (ir_bus[i])
    );
  end

  assign IR1 = ir_bus[0];
  assign IR2 = ir_bus[1];
  assign IR3 = ir_bus[2];

endmodule

// File: tb/tb_ir_track_emulator.sv
// Bench for ir_track_emulator: a clean default instance and a bouncy slow one,
// checked by a geometry table, hand sequences and a reference model on random en/dir.
module tb_ir_track_emulator;

  localparam int POS_MAX = 1000;
  localparam int LEN     = 160;

  logic CLK;
  logic RSTn;
  logic en;
  logic dir;
  logic [2:0] ir_a, ir_b;
  logic [9:0] pos_a, pos_b;
  logic step_a, step_b, stall_a, stall_b;

  int vectors;
  int miscompares;
  int edge_cnt;

  ir_track_emulator #(.STEP_DIV(4), .BOUNCE_N(0)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .en(en), .dir(dir),
    .IR1(ir_a[0]), .IR2(ir_a[1]), .IR3(ir_a[2]),
    .pos(pos_a), .step(step_a), .stall(stall_a)
  );

  ir_track_emulator #(.STEP_DIV(8), .BOUNCE_N(2)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .en(en), .dir(dir),
    .IR1(ir_b[0]), .IR2(ir_b[1]), .IR3(ir_b[2]),
    .pos(pos_b), .step(step_b), .stall(stall_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         edge_n;
    logic       en;
    logic       dir;
    int         pos;
    logic       stall;
    logic       step;
    logic [2:0] ir;
  } vec_t;

  vec_t tbl[$];

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int   div_n[2] = '{4, 8};
  int   bnc_n[2] = '{0, 2};
  int   beam[3]  = '{200, 250, 300};
  int   m_pos[2];
  int   m_streak[2];
  logic m_stall[2];
  logic m_step[2];
  logic lv[2][3];
  int   tc[2][3];

  function automatic vec_t mk(int e, logic en_v, logic dir_v, int p, logic st, logic sp, logic [2:0] irv);
    vec_t v;
    v.edge_n = e; v.en = en_v; v.dir = dir_v; v.pos = p;
    v.stall = st; v.step = sp; v.ir = irv;
    return v;
  endfunction

  function automatic logic blocked(int p, int beam_pos);
    return (p <= beam_pos) && (beam_pos <= p + LEN - 1);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en_v, input logic dir_v);
    en  = en_v;
    dir = dir_v;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    edge_cnt++;
  endtask

  task automatic doReset();
    RSTn = 1'b0;
    applyStimulus(1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic modelInit();
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = 0; m_streak[d] = 0; m_stall[d] = 1'b0; m_step[d] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        lv[d][k] = 1'b1;
        tc[d][k] = -1000;
      end
    end
  endtask

  // Advances one model by one clock edge using the en/dir present at that edge.
  task automatic modelEdge(input int d);
    logic id;
    for (int k = 0; k < 3; k++) begin
      id = !blocked(m_pos[d], beam[k]);
      if (id != lv[d][k]) begin
        lv[d][k] = id;
        tc[d][k] = edge_cnt;
      end
    end
    if (m_step[d]) begin
      if (dir && m_pos[d] < POS_MAX) begin
        m_pos[d]++; m_stall[d] = 1'b0;
      end else if (!dir && m_pos[d] > 0) begin
        m_pos[d]--; m_stall[d] = 1'b0;
      end else begin
        m_stall[d] = 1'b1;
      end
    end
    if (!en) m_stall[d] = 1'b0;
    m_streak[d] = en ? m_streak[d] + 1 : 0;
    m_step[d] = (m_streak[d] > 0) && (m_streak[d] % div_n[d] == div_n[d] - 1);
  endtask

  function automatic logic expIr(int d, int k);
    int age;
    age = edge_cnt - tc[d][k];
    if (age >= 2 * bnc_n[d] || age % 2 == 0) return lv[d][k];
    return ~lv[d][k];
  endfunction

  function automatic int expIrBus(int d);
    return {29'd0, expIr(d, 2), expIr(d, 1), expIr(d, 0)};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit expired");
  end

  initial begin
    int bseq[8];
    vectors = 0;
    miscompares = 0;
    edge_cnt = 0;
    RSTn = 1'b1;
    applyStimulus(1'b0, 1'b1);
    #2;

    // Reset state of both instances
    doReset();
    checkOutput("reset pos_a", pos_a, 0);
    checkOutput("reset ir_a", ir_a, 7);
    checkOutput("reset step_a", step_a, 0);
    checkOutput("reset stall_a", stall_a, 0);
    checkOutput("reset pos_b", pos_b, 0);
    checkOutput("reset ir_b", ir_b, 7);

    // Full forward/backward traversal of dut_a with hand-derived checkpoints
    tbl.push_back(mk(1,    1, 1, 0,    0, 0, 3'b111));
    tbl.push_back(mk(2,    1, 1, 0,    0, 0, 3'b111));
    tbl.push_back(mk(3,    1, 1, 0,    0, 1, 3'b111));
    tbl.push_back(mk(4,    1, 1, 1,    0, 0, 3'b111));
    tbl.push_back(mk(164,  1, 1, 41,   0, 0, 3'b111));
    tbl.push_back(mk(165,  1, 1, 41,   0, 0, 3'b110));
    tbl.push_back(mk(364,  1, 1, 91,   0, 0, 3'b110));
    tbl.push_back(mk(365,  1, 1, 91,   0, 0, 3'b100));
    tbl.push_back(mk(564,  1, 1, 141,  0, 0, 3'b100));
    tbl.push_back(mk(565,  1, 1, 141,  0, 0, 3'b000));
    tbl.push_back(mk(804,  1, 1, 201,  0, 0, 3'b000));
    tbl.push_back(mk(805,  1, 1, 201,  0, 0, 3'b001));
    tbl.push_back(mk(1004, 1, 1, 251,  0, 0, 3'b001));
    tbl.push_back(mk(1005, 1, 1, 251,  0, 0, 3'b011));
    tbl.push_back(mk(1204, 1, 1, 301,  0, 0, 3'b011));
    tbl.push_back(mk(1205, 1, 1, 301,  0, 0, 3'b111));
    tbl.push_back(mk(4000, 1, 1, 1000, 0, 0, 3'b111));
    tbl.push_back(mk(4003, 1, 1, 1000, 0, 1, 3'b111));
    tbl.push_back(mk(4004, 1, 1, 1000, 1, 0, 3'b111));
    tbl.push_back(mk(4007, 1, 0, 1000, 1, 1, 3'b111));
    tbl.push_back(mk(4008, 1, 0, 999,  0, 0, 3'b111));
    tbl.push_back(mk(6804, 1, 0, 300,  0, 0, 3'b111));
    tbl.push_back(mk(6805, 1, 0, 300,  0, 0, 3'b011));
    tbl.push_back(mk(7004, 1, 0, 250,  0, 0, 3'b011));
    tbl.push_back(mk(7005, 1, 0, 250,  0, 0, 3'b001));
    tbl.push_back(mk(7204, 1, 0, 200,  0, 0, 3'b001));
    tbl.push_back(mk(7205, 1, 0, 200,  0, 0, 3'b000));
    tbl.push_back(mk(7445, 1, 0, 140,  0, 0, 3'b100));
    tbl.push_back(mk(7844, 1, 0, 40,   0, 0, 3'b110));
    tbl.push_back(mk(7845, 1, 0, 40,   0, 0, 3'b111));
    tbl.push_back(mk(8007, 1, 0, 0,    0, 1, 3'b111));
    tbl.push_back(mk(8008, 1, 0, 0,    1, 0, 3'b111));
    tbl.push_back(mk(8009, 0, 0, 0,    0, 0, 3'b111));
    tbl.push_back(mk(8012, 0, 0, 0,    0, 0, 3'b111));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].en, tbl[i].dir);
      while (edge_cnt < tbl[i].edge_n) tick();
      checkOutput($sformatf("tbl edge %0d pos", edge_cnt), pos_a, tbl[i].pos);
      checkOutput($sformatf("tbl edge %0d stall", edge_cnt), stall_a, tbl[i].stall);
      checkOutput($sformatf("tbl edge %0d step", edge_cnt), step_a, tbl[i].step);
      checkOutput($sformatf("tbl edge %0d ir", edge_cnt), ir_a, tbl[i].ir);
    end

    // IR1 fall on the bouncy instance: 0,1,0,1,0 then stable 0
    doReset();
    applyStimulus(1'b1, 1'b1);
    bseq = '{1, 0, 1, 0, 1, 0, 0, 0};
    while (edge_cnt < 328) tick();
    checkOutput("bounce pos_b", pos_b, 41);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("bounce IR1 edge %0d", edge_cnt), ir_b[0], bseq[i]);
      tick();
    end

    // Reset in the middle of a traversal
    doReset();
    applyStimulus(1'b1, 1'b1);
    while (edge_cnt < 880) tick();
    checkOutput("midreset pre pos", pos_a, 220);
    checkOutput("midreset pre ir", ir_a, 3'b001);
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("midreset async ir", ir_a, 7);
    checkOutput("midreset async pos", pos_a, 0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    edge_cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("midreset pos edge %0d", i), pos_a, (i == 4) ? 1 : 0);
      checkOutput($sformatf("midreset step edge %0d", i), step_a, (i == 3) ? 1 : 0);
    end

    // Random en/dir against the reference model for both instances
    doReset();
    modelInit();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) dir = ~dir;
      if (c == 0) applyStimulus(1'b1, 1'b0);
      tick();
      modelEdge(0);
      modelEdge(1);
      checkOutput($sformatf("rnd %0d pos_a", c), pos_a, m_pos[0]);
      checkOutput($sformatf("rnd %0d stall_a", c), stall_a, m_stall[0]);
      checkOutput($sformatf("rnd %0d step_a", c), step_a, m_step[0]);
      checkOutput($sformatf("rnd %0d ir_a", c), ir_a, expIrBus(0));
      checkOutput($sformatf("rnd %0d pos_b", c), pos_b, m_pos[1]);
      checkOutput($sformatf("rnd %0d stall_b", c), stall_b, m_stall[1]);
      checkOutput($sformatf("rnd %0d step_b", c), step_b, m_step[1]);
      checkOutput($sformatf("rnd %0d ir_b", c), ir_b, expIrBus(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ir_track_emulator.md
Name: ir_track_emulator

Overview:
- Behavioural-synthesizable plant model of the motor carriage and its three IR break-beam sensors; the sensor-side counterpart of the direction-test controller.
- Consumes the controller's en/dir, moves a virtual carriage along a track, and drives IR1..IR3 with correct edge ordering, timing and optional contact bounce.
- Used in FPGA self-test builds, with a mux selecting real sensors or emulator, and as the closed-loop stimulus in controller benches.

Parameters:
POS_W, 10, position counter width
POS_MAX, 1000, upper end stop (inclusive)
HOME_POS, 0, carriage low-end position after reset
P1, 200, IR1 beam position
P2, 250, IR2 beam position
P3, 300, IR3 beam position
LEN, 160, carriage length in position units
STEP_DIV, 4, CLK cycles per position step (>=1)
BOUNCE_N, 0, extra glitch pairs per sensor transition (0 = clean)

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous, active-low reset
en  in  1  motor enable from controller
dir  in  1  1 = forward (increasing pos), 0 = backward
IR1  out  1  sensor 1, low = beam blocked
IR2  out  1  sensor 2, low = beam blocked
IR3  out  1  sensor 3, low = beam blocked
pos  out  POS_W  carriage low-end position
step  out  1  one-cycle pulse on each attempted step
stall  out  1  high while en=1 and the carriage sits at the end stop in the commanded direction

Behaviour:
- Reset: pos = HOME_POS, prescaler = 0, step = 0, stall = 0, IR1..IR3 = 1, bounce counters = 0.
- Elaboration constraints (assertion): P1 < P2 < P3 <= POS_MAX; LEN > P3-P1; HOME_POS+LEN-1 < P1; STEP_DIV > 2*BOUNCE_N+1 recommended.
- Prescaler:
  - en=0: prescaler clears to 0 and holds.
  - en=1: prescaler counts 0..STEP_DIV-1 and wraps. step pulses in the cycle the count equals STEP_DIV-1.
  - First step occurs STEP_DIV cycles after en rises.
- Position update on step, using dir sampled in the step cycle (a reversal takes effect at the next step):
  - dir=1 and pos<POS_MAX: pos+1.
  - dir=0 and pos>0: pos-1.
  - Otherwise pos holds and stall is set.
  - stall clears on the first step that moves the carriage, or when en=0.
- Blocking: blocked_k = (pos <= Pk) && (Pk <= pos+LEN-1). Compute at POS_W+1 bits; no wrap.
- Ideal level ideal_k = ~blocked_k is registered. IRk follows one cycle after pos changes (latency 1 with BOUNCE_N=0).
- Edge order is guaranteed by geometry:
  - forward: IR1 fall, IR2 fall, IR3 fall, IR1 rise, IR2 rise, IR3 rise.
  - backward: IR3 fall, IR2 fall, IR1 fall, IR3 rise, IR2 rise, IR1 rise.
- Bounce (per sensor):
  - When ideal_k changes, IRk takes the new level, then alternates old/new at 1-cycle intervals for BOUNCE_N pairs, ending stable at the new level.
  - Settling time is 2*BOUNCE_N+1 cycles.
  - If ideal_k changes again during a bounce, the sequence restarts toward the newer level.
- Reset mid-operation: all state returns to reset values immediately. IR outputs go to 1 asynchronously.
- Simultaneous en fall and step in the same cycle: the step completes and the prescaler clears the next cycle.

Decomposition:
- Shared package holds:
  - FW = 1'b1 and BW = 1'b0, shared with the controller.
  - Default track geometry constants (P1..P3, LEN, HOME_POS, POS_MAX).
- Sub-module ir_bounce_gen: one per sensor, 3 instances. Inputs CLK, RSTn, ideal, BOUNCE_N. Output ir. Contains the bounce counter and toggle FSM (IDLE, GLITCH).
- Top level holds the prescaler, position counter, stall logic and comparators.

Test Plan:
- Reset, then en=1, dir=1, defaults -> first step at cycle 4 after en; IR1 falls 1 cycle after pos=41, IR2 after pos=91, IR3 after pos=141; IR1/IR2/IR3 rise after pos=201/251/301.
- Continue forward to the end stop -> pos saturates at 1000, stall=1 from the step attempt at pos=1000, pos stays 1000. Set dir=0 -> stall clears on the next step, pos=999.
- Backward from pos=1000 -> IR3 falls after pos=300, IR2 after 250, IR1 after 200; IR3/IR2/IR1 rise after pos=140/90/40. Down to pos=0 -> stall=1.
- Close the loop with the direction-test controller from reset -> controller visits all 12 states and returns to sHOME (en=0) with the carriage at pos=40. The controller's dir output drops to BW after sFW5.
- BOUNCE_N=2, STEP_DIV=8, forward -> IR1 sequence at its fall: 0,1,0,1,0 then stable 0, settling in 5 cycles. The unprotected controller mis-steps; note this as expected.
- Assert RSTn low at pos=220 while IR1 is high and IR2 low -> IR1..IR3 = 1 immediately, pos = 0 on release, no step for 4 cycles after en.
